// File: rtl/mesh_router_node.sv
// Five-port mesh router node: per-input FIFOs, column-first routing and a
// round-robin arbiter per output with registered output flits.
module mesh_router_node #(
    parameter int X_ID       = 1,
    parameter int Y_ID       = 1,
    parameter int COORD_W    = 2,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                rt_clk,
    input  logic                rt_reset,
    input  logic [5*DATA_W-1:0] in_data,
    input  logic [4:0]          in_write,
    output logic [4:0]          in_full,
    output logic [5*DATA_W-1:0] out_data,
    output logic [4:0]          out_write,
    input  logic [4:0]          out_neighbor_full,
    output logic [4:0]          ovf_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_SOUTH = 3'd2;
    localparam logic [2:0] P_EAST  = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;

    logic [DATA_W-1:0] mem_q    [5][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d    [5][FIFO_DEPTH];
    logic [CNT_W-1:0]  cnt_q    [5];
    logic [CNT_W-1:0]  cnt_d    [5];
    logic [PTR_W-1:0]  rd_ptr_q [5];
    logic [PTR_W-1:0]  rd_ptr_d [5];
    logic [PTR_W-1:0]  wr_ptr_q [5];
    logic [PTR_W-1:0]  wr_ptr_d [5];
    logic [2:0]        rr_q     [5];
    logic [2:0]        rr_d     [5];
    logic [4:0]        ovf_q, ovf_d;
    logic [4:0]        owrite_q, owrite_d;
    logic [5*DATA_W-1:0] odata_q, odata_d;

    logic [DATA_W-1:0] head  [5];
    logic [2:0]        route [5];
    logic [4:0]        req   [5];
    logic [4:0]        gnt   [5];
    logic [4:0]        granted;
    logic [4:0]        pop;
    logic [4:0]        push;

    function automatic logic [2:0] route_of(input logic [DATA_W-1:0] f);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = f[DATA_W-1 -: COORD_W];
        dy = f[DATA_W-1-COORD_W -: COORD_W];
        if (dy > COORD_W'(Y_ID))      return P_EAST;
        else if (dy < COORD_W'(Y_ID)) return P_WEST;
        else if (dx > COORD_W'(X_ID)) return P_SOUTH;
        else if (dx < COORD_W'(X_ID)) return P_NORTH;
        else                          return P_LOCAL;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(FIFO_DEPTH - 1)) ? '0 : v + 1'b1;
    endfunction

    // A non-local input routed back to its own port never requests: only local may U-turn.
    always_comb begin
        for (int unsigned p = 0; p < 5; p++) begin
            head[p]    = mem_q[p][rd_ptr_q[p]];
            route[p]   = route_of(head[p]);
            in_full[p] = (cnt_q[p] >= CNT_W'(FIFO_DEPTH - 1));
        end
        for (int unsigned o = 0; o < 5; o++) begin
            for (int unsigned p = 0; p < 5; p++) begin
                req[o][p] = (cnt_q[p] != '0) && (route[p] == 3'(o)) && !(p != 0 && p == o);
            end
        end
    end

    always_comb begin
        int unsigned idx;
        idx     = 0;
        granted = '0;
        pop     = '0;
        for (int unsigned o = 0; o < 5; o++) begin
            gnt[o] = '0;
            rr_d[o] = rr_q[o];
            if (!out_neighbor_full[o]) begin
                for (int unsigned k = 0; k < 5; k++) begin
                    idx = (32'(rr_q[o]) + k) % 5;
                    if (!granted[o] && req[o][idx]) begin
                        gnt[o][idx] = 1'b1;
                        granted[o]  = 1'b1;
                        rr_d[o]     = (idx == 4) ? 3'd0 : 3'(idx + 1);
                    end
                end
            end
            pop = pop | gnt[o];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        odata_d  = odata_q;
        owrite_d = '0;
        push     = '0;
        for (int unsigned o = 0; o < 5; o++) begin
            for (int unsigned p = 0; p < 5; p++) begin
                if (gnt[o][p]) begin
                    odata_d[o*DATA_W +: DATA_W] = head[p];
                    owrite_d[o] = 1'b1;
                end
            end
        end
        for (int unsigned p = 0; p < 5; p++) begin
            push[p] = in_write[p] && (cnt_q[p] != CNT_W'(FIFO_DEPTH));
            if (in_write[p] && !push[p]) ovf_d[p] = 1'b1;
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = in_data[p*DATA_W +: DATA_W];
                wr_ptr_d[p] = ptr_inc(wr_ptr_q[p]);
            end
            if (pop[p]) rd_ptr_d[p] = ptr_inc(rd_ptr_q[p]);
            case ({push[p], pop[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + 1'b1;
                2'b01:   cnt_d[p] = cnt_q[p] - 1'b1;
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
    end

    always_ff @(posedge rt_clk or posedge rt_reset) begin
        if (rt_reset) begin
            mem_q    <= '{default: '0};
            cnt_q    <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            wr_ptr_q <= '{default: '0};
            rr_q     <= '{default: '0};
            ovf_q    <= '0;
            owrite_q <= '0;
            odata_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rr_q     <= rr_d;
            ovf_q    <= ovf_d;
            owrite_q <= owrite_d;
            odata_q  <= odata_d;
        end
    end

    assign out_data  = odata_q;
    assign out_write = owrite_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_mesh_router_node.sv
// Directed bench for mesh_router_node (node 1,1): expected flits are queued per
// output with their due cycle and checked by an independent output monitor.
module tb_mesh_router_node;
    logic        rt_clk;
    logic        rt_reset;
    logic [39:0] in_data;
    logic [4:0]  in_write;
    logic [4:0]  in_full;
    logic [39:0] out_data;
    logic [4:0]  out_write;
    logic [4:0]  out_neighbor_full;
    logic [4:0]  ovf_err;

    mesh_router_node #(.X_ID(1), .Y_ID(1), .COORD_W(2), .DATA_W(8), .FIFO_DEPTH(4)) dut (
        .rt_clk(rt_clk),
        .rt_reset(rt_reset),
        .in_data(in_data),
        .in_write(in_write),
        .in_full(in_full),
        .out_data(out_data),
        .out_write(out_write),
        .out_neighbor_full(out_neighbor_full),
        .ovf_err(ovf_err)
    );

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t exp_q [5][$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   t;
    int   r;

    initial rt_clk = 1'b0;
    always #5 rt_clk = ~rt_clk;
    always @(posedge rt_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge rt_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void expect_out(input int o, input logic [7:0] d, input int c);
        exp_t e;
        e.d = d;
        e.c = c;
        exp_q[o].push_back(e);
    endfunction

    // Drive one cycle of writes; returns the cycle index of the sampling edge.
    task automatic send(input logic [4:0] mask, input logic [39:0] data, output int tt);
        in_write = mask;
        in_data  = data;
        tick();
        tt       = cyc;
        in_write = '0;
        in_data  = '0;
    endtask

    always @(negedge rt_clk) begin
        for (int o = 0; o < 5; o++) begin
            if (out_write[o] === 1'b1) begin
                n_chk++;
                if (exp_q[o].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write port %0d: actual data=%0h cycle=%0d required=no write",
                             o, out_data[o*8 +: 8], cyc);
                end else begin
                    exp_t e;
                    e = exp_q[o].pop_front();
                    if (out_data[o*8 +: 8] !== e.d || (e.c != 0 && e.c != cyc)) begin
                        n_fail++;
                        $display("FAIL out_flit port %0d: actual data=%0h cycle=%0d required data=%0h cycle=%0d",
                                 o, out_data[o*8 +: 8], cyc, e.d, e.c);
                    end
                end
            end
        end
    end

    initial begin
        rt_reset          = 1'b1;
        in_write          = '0;
        in_data           = '0;
        out_neighbor_full = '0;
        repeat (2) tick();
        check("reset_in_full", {35'd0, in_full}, 40'd0);
        check("reset_out_write", {35'd0, out_write}, 40'd0);
        check("reset_out_data", out_data, 40'd0);
        check("reset_ovf_err", {35'd0, ovf_err}, 40'd0);
        rt_reset = 1'b0;

        // Routing from local: one flit per cycle to five different outputs.
        send(5'b00001, 40'h63, t); expect_out(3, 8'h63, t + 1);
        send(5'b00001, 40'h50, t); expect_out(0, 8'h50, t + 1);
        send(5'b00001, 40'h90, t); expect_out(2, 8'h90, t + 1);
        send(5'b00001, 40'h10, t); expect_out(1, 8'h10, t + 1);
        send(5'b00001, 40'h40, t); expect_out(4, 8'h40, t + 1);
        repeat (4) tick();
        check("hold_out_data_east", {32'd0, out_data[3*8 +: 8]}, 40'h63);
        check("idle_out_write", {35'd0, out_write}, 40'd0);

        // North and west to local in the same cycle: north first, then west.
        rt_reset = 1'b1; tick(); rt_reset = 1'b0;
        send(5'b10010, {8'h54, 8'h00, 8'h00, 8'h51, 8'h00}, t);
        expect_out(0, 8'h51, t + 1);
        expect_out(0, 8'h54, t + 2);
        repeat (4) tick();

        // Back-pressure on east: in_full after three, then drain in order.
        out_neighbor_full = 5'b01000;
        send(5'b00001, 40'h61, t);
        send(5'b00001, 40'h62, t);
        check("in_full_at_2", {35'd0, in_full}, 40'd0);
        send(5'b00001, 40'h63, t);
        check("in_full_at_3", {35'd0, in_full}, 40'h01);
        repeat (3) tick();
        out_neighbor_full = '0;
        r = cyc;
        expect_out(3, 8'h61, r + 1);
        expect_out(3, 8'h62, r + 2);
        expect_out(3, 8'h63, r + 3);
        repeat (5) tick();
        check("in_full_drained", {35'd0, in_full}, 40'd0);

        // Overflow: fifth write dropped, sticky error, exactly four drained.
        out_neighbor_full = 5'b01000;
        for (int i = 0; i < 5; i++) send(5'b00001, 40'(8'h61 + i), t);
        check("ovf_after_5th", {35'd0, ovf_err}, 40'h01);
        check("in_full_when_full", {35'd0, in_full}, 40'h01);
        repeat (2) tick();
        out_neighbor_full = '0;
        r = cyc;
        for (int i = 0; i < 4; i++) expect_out(3, 8'(8'h61 + i), r + 1 + i);
        repeat (8) tick();
        check("ovf_sticky", {35'd0, ovf_err}, 40'h01);

        // Asynchronous reset with three flits buffered.
        out_neighbor_full = 5'b01000;
        send(5'b00001, 40'h61, t);
        send(5'b00001, 40'h62, t);
        send(5'b00001, 40'h63, t);
        #2 rt_reset = 1'b1;
        #1;
        check("async_rst_out_data", out_data, 40'd0);
        check("async_rst_out_write", {35'd0, out_write}, 40'd0);
        check("async_rst_in_full", {35'd0, in_full}, 40'd0);
        check("async_rst_ovf", {35'd0, ovf_err}, 40'd0);
        tick();
        out_neighbor_full = '0;
        rt_reset = 1'b0;
        repeat (4) tick();
        send(5'b00001, 40'h90, t); expect_out(2, 8'h90, t + 1);
        repeat (3) tick();

        // Local and north contend for east; west streams south concurrently.
        for (int i = 0; i < 6; i++) begin
            logic [4:0]  m;
            logic [39:0] d;
            m = (i < 3) ? 5'b10011 : 5'b10000;
            d = {8'(8'h91 + i), 8'h00, 8'h00, 8'(8'h6A + i), 8'(8'h61 + i)};
            send(m, d, t);
            if (i < 3) begin
                expect_out(3, 8'(8'h61 + i), t + 1 + i);
                expect_out(3, 8'(8'h6A + i), t + 2 + i);
            end
            expect_out(2, 8'(8'h91 + i), t + 1);
        end
        repeat (10) tick();

        for (int o = 0; o < 5; o++) check($sformatf("pending_port%0d", o), 40'(exp_q[o].size()), 40'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mesh_router_node.md
MESH_ROUTER_NODE -- requirements
Module: mesh_router_node

Interface
REQ-001 Parameter X_ID, default 1: mesh row index of this node; row increases southward.
REQ-002 Parameter Y_ID, default 1: mesh column index of this node; column increases eastward.
REQ-003 Parameter COORD_W, default 2: width of each destination coordinate field.
REQ-004 Parameter DATA_W, default 8: flit width; must be >= 2*COORD_W.
REQ-005 Parameter FIFO_DEPTH, default 4: entries per input FIFO; must be >= 2.
REQ-006 Port indexing for all 5-wide buses: 0=local, 1=north, 2=south, 3=east, 4=west; data buses pack port p at [p*DATA_W +: DATA_W].
REQ-007 rt_clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rt_reset  input  1  asynchronous, active-high reset.
REQ-009 in_data  input  5*DATA_W  incoming flit per port.
REQ-010 in_write  input  5  write enable per input port; flit sampled when high.
REQ-011 in_full  output  5  per-input FIFO full flag to the upstream sender.
REQ-012 out_data  output  5*DATA_W  outgoing flit per port, registered.
REQ-013 out_write  output  5  one-cycle write request per output port, registered.
REQ-014 out_neighbor_full  input  5  full flag from the downstream receiver per output port.
REQ-015 ovf_err  output  5  sticky overflow flag per input port.

Function
REQ-016 Single-flit packets: dest_x = flit[DATA_W-1 -: COORD_W], dest_y = flit[DATA_W-1-COORD_W -: COORD_W]; flit passes through unmodified.
REQ-017 Route computation (column first): dest_y>Y_ID->east; dest_y<Y_ID->west; otherwise dest_x>X_ID->south; dest_x<X_ID->north; otherwise local.
REQ-018 Each input port owns a FIFO_DEPTH-entry FIFO with an occupancy count; in_write with count<FIFO_DEPTH pushes at the rising edge.
REQ-019 in_full[p] is high when count[p] >= FIFO_DEPTH-1 (one-slot skid for the one-cycle in-flight write).
REQ-020 A write with count==FIFO_DEPTH is dropped, FIFO unchanged, ovf_err[p] set to 1 and held until reset.
REQ-021 Simultaneous push and pop on one FIFO: both take effect, count unchanged.
REQ-022 Each non-empty FIFO head requests exactly one output per REQ-017.
REQ-023 Each output grants at most one requester per cycle via round-robin; the pointer resets to 0, the search starts at the pointer index, and after a grant to port p the pointer becomes (p+1) mod 5.
REQ-024 No grant on output o while out_neighbor_full[o] is high; the pointer does not advance without a grant.
REQ-025 A grant pops the winning FIFO head and, at the same edge, loads out_data[o] and sets out_write[o]=1 for exactly that cycle; out_write[o]=0 on cycles with no grant, and out_data[o] holds its last value.
REQ-026 Latency: a flit sampled at edge t into an empty FIFO with a free output appears with out_write high after edge t+1.
REQ-027 Throughput: one flit per output per cycle; distinct outputs operate concurrently.
REQ-028 Per-input ordering is preserved; flits from one input to one output leave in arrival order.
REQ-029 U-turns are permitted only on the local port (local->local).

Reset
REQ-030 While rt_reset is high: all FIFO counts and pointers are 0, in_full=0, out_write=0, out_data=0, ovf_err=0, and RR pointers are 0.
REQ-031 Assertion mid-operation discards all buffered flits immediately, with no out_write pulse.
REQ-032 The first push is accepted at the first rising edge after rt_reset deasserts.

Verification (X_ID=1, Y_ID=1, COORD_W=2, DATA_W=8, FIFO_DEPTH=4)
REQ-033 Local write 0x63 (dest 1,2) -> out_write[3]=1, out_data[3]=0x63 one cycle later; 0x50 -> port 0; 0x90 -> port 2; 0x10 -> port 1; 0x40 -> port 4.
REQ-034 North and west write 0x50 in the same cycle after reset -> local out_write high two consecutive cycles, north flit first, then west.
REQ-035 out_neighbor_full[3]=1; local writes 0x61,0x62,0x63 -> in_full[0]=1 after the third, no out_write[3]; release -> 0x61,0x62,0x63 on consecutive cycles; in_full[0] returns to 0.
REQ-036 Out_neighbor_full[3] held high; 5 local writes ignoring in_full -> 5th dropped, ovf_err[0]=1 sticky; drain yields exactly 4 flits.
REQ-037 rt_reset pulsed with 3 flits buffered -> outputs 0 asynchronously, no later out_write; a fresh write routes normally.
REQ-038 Continuous east-bound traffic on local and north while south traffic flows -> east alternates 0,1,0,1...; south sustains one flit per cycle.
